// File: rtl/prio_encoder_pipe.sv
// Registered request-vector encoder with four run-time modes (one-hot, LSB, MSB, round-robin),
// valid/ready handshake on both sides and a saturating strict-mode error counter.
module prio_encoder_pipe #(
  parameter int IN_W  = 16,
  parameter int CNT_W = 8,
  localparam int OUT_W = $clog2(IN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  encoder_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] binary_out,
  output logic             out_found,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
);

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] binary_q, binary_d;
  logic             found_q, found_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [OUT_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             accept;
  logic [OUT_W-1:0] lsb_idx, msb_idx, rr_hi_idx, rr_idx;
  logic             any_set, multi_set, seen, rr_hi_found;
  logic [OUT_W-1:0] calc_idx;
  logic             calc_found, calc_err;

  assign in_ready = enable & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // Round-robin = lowest set bit at or above rr_ptr, else lowest set bit overall (the wrap).
  always_comb begin
    lsb_idx     = '0;
    msb_idx     = '0;
    rr_hi_idx   = '0;
    rr_hi_found = 1'b0;
    multi_set   = 1'b0;
    seen        = 1'b0;
    any_set     = |encoder_in;
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (encoder_in[i]) begin
        lsb_idx = OUT_W'(i);
        if (i >= int'(rr_ptr_q)) begin
          rr_hi_idx   = OUT_W'(i);
          rr_hi_found = 1'b1;
        end
      end
    end
    for (int i = 0; i < IN_W; i++) begin
      if (encoder_in[i]) begin
        msb_idx   = OUT_W'(i);
        multi_set = multi_set | seen;
        seen      = 1'b1;
      end
    end
    rr_idx = rr_hi_found ? rr_hi_idx : lsb_idx;
  end

  always_comb begin
    calc_idx   = '0;
    calc_found = 1'b0;
    calc_err   = 1'b0;
    if (any_set) begin
      case (mode)
        2'd0: begin
          if (multi_set) begin
            calc_err = 1'b1;
          end else begin
            calc_idx   = lsb_idx;
            calc_found = 1'b1;
          end
        end
        2'd1: begin
          calc_idx   = lsb_idx;
          calc_found = 1'b1;
        end
        2'd2: begin
          calc_idx   = msb_idx;
          calc_found = 1'b1;
        end
        default: begin
          calc_idx   = rr_idx;
          calc_found = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    binary_d    = binary_q;
    found_d     = found_q;
    err_d       = err_q;
    rr_ptr_d    = rr_ptr_q;
    err_count_d = err_count_q;
    if (accept) begin
      out_valid_d = 1'b1;
      binary_d    = calc_idx;
      found_d     = calc_found;
      err_d       = calc_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // Wrap explicitly at IN_W so non-power-of-2 widths never point past the vector.
    if (accept && (mode == 2'd3) && any_set) begin
      rr_ptr_d = (rr_idx == OUT_W'(IN_W - 1)) ? '0 : rr_idx + 1'b1;
    end
    if (err_clr) begin
      err_count_d = '0;
    end else if (accept && calc_err && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      binary_q    <= '0;
      found_q     <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      binary_q    <= binary_d;
      found_q     <= found_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign binary_out = binary_q;
  assign out_found  = found_q;
  assign out_err    = err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Directed bench for prio_encoder_pipe: a 16-bit instance with a 2-bit error counter
// and a 5-bit instance for non-power-of-2 round-robin wrap.
module tb_prio_encoder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  mode;
  logic        out_ready;
  logic        err_clr;

  logic        a_in_valid, a_in_ready, a_out_valid, a_found, a_err;
  logic [15:0] a_in;
  logic [3:0]  a_bin;
  logic [1:0]  a_cnt;

  logic        b_in_valid, b_in_ready, b_out_valid, b_found, b_err;
  logic [4:0]  b_in;
  logic [2:0]  b_bin;
  logic [7:0]  b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  prio_encoder_pipe #(.IN_W(16), .CNT_W(2)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .encoder_in(a_in),
    .out_valid(a_out_valid), .out_ready(out_ready), .binary_out(a_bin),
    .out_found(a_found), .out_err(a_err), .err_count(a_cnt), .err_clr(err_clr)
  );

  prio_encoder_pipe #(.IN_W(5), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .encoder_in(b_in),
    .out_valid(b_out_valid), .out_ready(out_ready), .binary_out(b_bin),
    .out_found(b_found), .out_err(b_err), .err_count(b_cnt), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [1:0] m, input logic [15:0] v);
    mode = m; a_in = v; a_in_valid = 1'b1;
    tick();
  endtask

  // expected binary_out for round-robin 0x8001 sequence
  logic [3:0] rr_exp [4];

  initial begin
    rr_exp[0] = 4'd0; rr_exp[1] = 4'd15; rr_exp[2] = 4'd0; rr_exp[3] = 4'd15;
    rst_n = 1'b0; enable = 1'b0; mode = 2'd0; out_ready = 1'b0; err_clr = 1'b0;
    a_in_valid = 1'b0; a_in = '0; b_in_valid = 1'b0; b_in = '0;
    #2;
    chk("rst_valid", a_out_valid, 0);
    chk("rst_bin",   a_bin, 0);
    chk("rst_found", a_found, 0);
    chk("rst_err",   a_err, 0);
    chk("rst_cnt",   a_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    enable = 1'b1; out_ready = 1'b1;
    mode = 2'd1; a_in = 16'h0028; a_in_valid = 1'b1;
    #1 chk("in_ready_idle", a_in_ready, 1);
    tick();
    chk("lsb_valid", a_out_valid, 1);
    chk("lsb_bin",   a_bin, 3);
    chk("lsb_found", a_found, 1);
    chk("lsb_err",   a_err, 0);

    send_a(2'd2, 16'h0028);
    chk("msb_bin", a_bin, 5);
    chk("msb_found", a_found, 1);

    send_a(2'd0, 16'h8000);
    chk("oh_bin", a_bin, 15);
    chk("oh_found", a_found, 1);
    send_a(2'd0, 16'h0006);
    chk("oh_multi_found", a_found, 0);
    chk("oh_multi_err", a_err, 1);
    chk("oh_multi_bin", a_bin, 0);
    chk("oh_multi_cnt", a_cnt, 1);

    send_a(2'd1, 16'h0000);
    chk("zero_found", a_found, 0);
    chk("zero_bin", a_bin, 0);
    chk("zero_err", a_err, 0);

    for (int i = 0; i < 4; i++) begin
      send_a(2'd3, 16'h8001);
      chk($sformatf("rr_%0d", i), a_bin, rr_exp[i]);
      if (i == 1) chk("rr_ptr_wrap", u_a.rr_ptr_q, 0);
    end
    send_a(2'd3, 16'h0004);
    chk("rr_b2", a_bin, 2);
    send_a(2'd1, 16'h0001);
    chk("rr_ptr_kept", u_a.rr_ptr_q, 3);
    send_a(2'd3, 16'h0005);
    chk("rr_wrap_search", a_bin, 0);
    send_a(2'd3, 16'h0000);
    chk("rr_zero_found", a_found, 0);
    chk("rr_zero_ptr", u_a.rr_ptr_q, 1);
    send_a(2'd3, 16'h0003);
    chk("rr_from1", a_bin, 1);

    out_ready = 1'b0; mode = 2'd1; a_in = 16'h0100;
    #1 chk("hold_in_ready0", a_in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_bin", a_bin, 1);
      chk("hold_valid", a_out_valid, 1);
      chk("hold_in_ready", a_in_ready, 0);
    end
    out_ready = 1'b1;
    #1 chk("release_in_ready", a_in_ready, 1);
    tick();
    chk("release_bin", a_bin, 8);
    chk("release_valid", a_out_valid, 1);

    a_in_valid = 1'b0;
    tick();
    chk("drain_valid", a_out_valid, 0);

    enable = 1'b0; a_in_valid = 1'b1;
    #1 chk("dis_in_ready", a_in_ready, 0);
    tick();
    chk("dis_no_accept", a_out_valid, 0);

    enable = 1'b1; mode = 2'd2; a_in = 16'h0011;
    tick();
    out_ready = 1'b0; enable = 1'b0;
    tick();
    chk("dis_hold_valid", a_out_valid, 1);
    chk("dis_hold_bin", a_bin, 4);
    out_ready = 1'b1;
    tick();
    chk("dis_drained", a_out_valid, 0);

    enable = 1'b1; a_in_valid = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_cnt", a_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      send_a(2'd0, 16'h0003);
      chk($sformatf("sat_%0d", i), a_cnt, (i < 3) ? i + 1 : 3);
    end
    err_clr = 1'b1;
    send_a(2'd0, 16'h0003);
    err_clr = 1'b0;
    chk("clr_wins", a_cnt, 0);

    send_a(2'd0, 16'h0003);
    out_ready = 1'b0; a_in_valid = 1'b0;
    chk("pre_rst_cnt", a_cnt, 1);
    chk("pre_rst_valid", a_out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", a_out_valid, 0);
    chk("async_rst_cnt", a_cnt, 0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);

    mode = 2'd3; b_in = 5'b10001; b_in_valid = 1'b1;
    tick(); chk("b_rr_0", b_bin, 0);
    tick(); chk("b_rr_1", b_bin, 4);
    chk("b_rr_ptr", u_b.rr_ptr_q, 0);
    tick(); chk("b_rr_2", b_bin, 0);
    chk("b_found", b_found, 1);
    mode = 2'd2; b_in = 5'b01010;
    tick(); chk("b_msb", b_bin, 3);
    b_in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prio_encoder_pipe.md
Name: prio_encoder_pipe

Overview:
- Parametrised, registered successor to the team's 16-to-4 case encoder.
- Encodes an IN_W-bit request vector to a binary index in one of four run-time modes: strict one-hot, LSB-priority, MSB-priority and round-robin.
- Valid/ready handshake on both sides, one-stage output register, and a saturating error counter.
- Sits between request-generating logic and any consumer of a binary index, e.g. arbiter grant decode or interrupt ID.

Parameters:
- IN_W, 16, request vector width; legal range 2..1024; need not be a power of 2.
- OUT_W, $clog2(IN_W), index width; derived, not overridden.
- CNT_W, 8, error counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  block enable; low forces in_ready=0 (output stage still drains).
- mode  input  2  0=strict one-hot, 1=LSB-first priority, 2=MSB-first priority, 3=round-robin.
- in_valid  input  1  request vector valid.
- in_ready  output  1  block can accept.
- encoder_in  input  IN_W  request vector.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- binary_out  output  OUT_W  encoded index.
- out_found  output  1  a legal index was produced.
- out_err  output  1  strict-mode violation (more than one bit set).
- err_count  output  CNT_W  saturating count of accepted out_err results.
- err_clr  input  1  synchronous clear of err_count.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, binary_out=0, out_found=0, out_err=0, err_count=0, rr_ptr=0. Internal rr_ptr is OUT_W bits.
- Reset mid-transfer: a pending result is discarded. Release is sampled on the next rising edge.
- in_ready = enable & (!out_valid | out_ready), purely combinational.
- Accept occurs when in_valid & in_ready. mode and encoder_in are sampled together at accept.
- Latency: the result is registered at the accepting edge, so out_valid=1 from the next cycle.
- Full throughput: back-to-back accepts are allowed while out_ready=1.
- Output hold: if out_valid & !out_ready, all outputs stay stable and in_ready=0.
- out_valid clears after a transfer (out_valid & out_ready) with no new accept in the same cycle.
- Zero input, any mode: out_found=0, binary_out=0, out_err=0, rr_ptr unchanged.
- Mode 0, exactly one bit k set: binary_out=k, found=1.
- Mode 0, two or more bits set: binary_out=0, found=0, out_err=1.
- Mode 1: binary_out = lowest set index, found=1.
- Mode 2: binary_out = highest set index, found=1.
- Mode 3, search:
  - Start at rr_ptr, ascend, wrap from IN_W-1 to 0; the first set bit wins.
  - On found, rr_ptr <= (winner==IN_W-1) ? 0 : winner+1. Wrap at IN_W explicitly, not modulo 2^OUT_W.
  - rr_ptr changes only on accepts in mode 3; other modes leave it untouched.
- out_err is 0 in modes 1-3.
- err_count:
  - Increments by 1 on an accept whose computed out_err=1; counted at accept, not at output transfer.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - err_clr=1 sets it to 0. Clear wins over a simultaneous increment.
- enable falling while out_valid=1: the held result still completes its handshake; no new accepts.

Test Plan:
- Reset then IN_W=16, mode=1, encoder_in=16'h0028, out_ready=1 -> next cycle out_valid=1, binary_out=3, found=1, err=0.
- mode=2, encoder_in=16'h0028 -> binary_out=5.
- mode=0 with 16'h8000 -> binary_out=15, found=1. Then 16'h0006 -> found=0, err=1, err_count=1.
- mode=3, in_valid held, encoder_in=16'h8001 for 4 accepts -> binary_out sequence 0,15,0,15. rr_ptr after the second accept =0 (wrap).
- out_ready=0 for 3 cycles after a result -> binary_out stable, in_ready=0, no accept. Then out_ready=1 -> transfer completes and the next input is accepted in the same cycle.
- CNT_W=2: 5 consecutive mode-0 accepts of 16'h0003 -> err_count 1,2,3,3,3. err_clr asserted together with a 6th error -> err_count=0.
- rst_n pulsed low while out_valid=1 and out_ready=0 -> out_valid=0 and err_count=0 immediately, without a clock edge.
- IN_W=5, mode=3, repeated 5'b10001 -> binary_out 0,4,0, wrap correct for a non-power-of-2 width.
